// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        byte_en;
  } mem_req_t;

  localparam int CNT_W = 4;

  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;
  localparam logic [3:0] LANE_MASK_B0   = 4'b0001;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return LANE_MASK_B0 << lane;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word array: byte-lane synchronous write, registered read.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are deliberately unreset so they survive a core reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request, stalls the pipeline
// for LATENCY cycles, then returns load data / fault status in the RESP cycle.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        MemDoneM,
  output logic        MemFaultM
);

  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  mem_req_t         req, cur;
  logic             req_fault, cur_fault;
  logic             accept, enter_resp;
  logic             rd_zero, rd_byte;
  logic [1:0]       rd_lane;
  logic [31:0]      arr_q;
  logic [3:0]       wmask;
  logic [31:0]      arr_wdata;

  function automatic logic addr_fault(input logic [31:0] a, input logic is_byte);
    return (!is_byte && (a[1:0] != 2'b00)) || (a[31:AW+2] != '0);
  endfunction

  // In IDLE the live inputs are the request; afterwards only the latched copy counts.
  always_comb begin
    cur = req;
    if (state == IDLE) begin
      cur.addr    = ALUResultM;
      cur.wdata   = WriteDataM;
      cur.we      = MemWriteM;
      cur.byte_en = ByteM;
    end
  end

  assign cur_fault = addr_fault(cur.addr, cur.byte_en);

  always_comb begin
    state_nxt = state;
    MemStallM = 1'b0;
    MemDoneM  = 1'b0;
    MemFaultM = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        MemStallM = MemReqM;
        if (MemReqM) begin
          accept    = 1'b1;
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        MemStallM = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        MemDoneM  = 1'b1;
        MemFaultM = req_fault;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && !reset;

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_fault <= 1'b0;
      rd_zero   <= 1'b1;
      rd_byte   <= 1'b0;
      rd_lane   <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt       <= CNT_W'(LATENCY - 1);
        req_fault <= cur_fault;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        rd_zero <= cur_fault;
        rd_byte <= cur.byte_en;
        rd_lane <= cur.addr[1:0];
      end
    end
  end

  // ---- request data register ----
  always_ff @(posedge clk) begin
    if (accept) req <= cur;
  end

  // Write commits at the closing edge of RESP; reset in RESP drops it.
  always_comb begin
    wmask = 4'b0000;
    if ((state == RESP) && req.we && !req_fault && !reset)
      wmask = req.byte_en ? lane_mask(req.addr[1:0]) : LANE_MASK_WORD;
  end

  assign arr_wdata = req.byte_en ? {4{req.wdata[7:0]}} : req.wdata;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .wmask (wmask),
    .waddr (req.addr[AW+1:2]),
    .wdata (arr_wdata),
    .re    (enter_resp),
    .raddr (cur.addr[AW+1:2]),
    .rdata (arr_q)
  );

  // Every source here is loaded on entry to RESP, so the value holds until the next one.
  always_comb begin
    if (rd_zero)      ReadDataM = 32'h0;
    else if (rd_byte) ReadDataM = {24'h0, arr_q[8*rd_lane +: 8]};
    else              ReadDataM = arr_q;
  end

endmodule
